projectile_scheduler: RTL and testbench
=======================================

// Module: projectile_scheduler
// PURPOSE
//  Owns the single shared projectile engine and sequences its use by both players.
//  Arbitrates special-attack requests round-robin and latches the launch origin and direction.
//  Tracks each flight to completion or timeout and enforces a per-player cooldown.
//  Reports hits as per-player pulses. Sits between the input/attack decoders and the engine.
// PARAMETERS
//  COOLDOWN_TICKS  40   ticks a player is blocked after their projectile ends (1..255)
//  TIMEOUT_TICKS   120  ticks in FLIGHT before forced abort (1..255)
//  RAISE           5    pixels launch_y sits above the shooter's y
// PORTS
//  clk           in   1  system clock; sole clock
//  rst_n         in   1  asynchronous, active-low reset
//  tick          in   1  1-cycle game-tick strobe (~40 Hz), synchronous to clk
//  req           in   2  level; req[i]=1 while player i is in special-attack state
//  p1_x, p1_y    in   7  player 1 position (OLED pixels, 96x64)
//  p2_x, p2_y    in   7  player 2 position
//  mirrored      in   2  mirrored[i]=1 means player i faces left
//  eng_busy      in   1  engine has a projectile in flight
//  eng_done      in   1  1-cycle pulse: projectile ended (hit or screen edge)
//  eng_hit       in   1  qualifies eng_done: projectile struck the opponent
//  launch        out  1  1-cycle pulse: engine must start a projectile
//  launch_x      out  7  origin x; held stable from launch until next launch
//  launch_y      out  7  origin y; held stable from launch until next launch
//  launch_dir    out  1  1 = move left (decreasing x)
//  owner         out  1  index of the player owning the current/last projectile
//  abort         out  1  1-cycle pulse: engine must kill projectile (timeout)
//  hit_pulse     out  2  hit_pulse[i]=1 for 1 cycle: player i was hit
//  cooling       out  2  cooling[i]=1 while player i's cooldown counter is nonzero
// BEHAVIOUR
//  Reset values
//   - All outputs 0; FSM IDLE; cooldown counters 0; rr pointer 1 (player 0 wins first tie).
//   - Reset mid-FLIGHT returns to IDLE with no abort pulse; the engine is reset by the same rst_n.
//  Eligibility
//   - elig[i] = req[i] & ~cooling[i].
//  FSM (one state register, three states)
//   - IDLE: if eng_busy=0 and elig!=0 -> LAUNCH.
//       Grant: the single eligible player; if both are eligible, the player != rr pointer.
//       Latch owner, launch_x = shooter x, launch_dir = mirrored[owner],
//       launch_y = shooter y - RAISE, saturating at 0.
//   - LAUNCH (1 cycle): launch=1; rr pointer <= owner; clear timeout counter -> FLIGHT.
//   - FLIGHT: count ticks.
//       eng_done=1 -> IDLE; if eng_hit, hit_pulse[~owner]=1 in the same cycle as the transition.
//       Else timeout counter reaches TIMEOUT_TICKS on a tick -> abort=1 for 1 cycle -> IDLE.
//       eng_done and the timeout tick in the same cycle: done wins, no abort.
//  Latency
//   - IDLE-with-eligible-request to launch = 1 cycle.
//   - eng_done to hit_pulse = 1 cycle (registered).
//  Requests
//   - Not queued. Requests in LAUNCH/FLIGHT are ignored.
//   - A request still held on return to IDLE is served, subject to cooldown.
//   - A held req refires after cooldown expires; this is intended auto-repeat.
//  Cooldown
//   - On leaving FLIGHT (done or abort), counter[owner] <= COOLDOWN_TICKS.
//   - Otherwise counter[i] decrements on tick while nonzero.
//   - A load and a tick in the same cycle: load wins.
//   - The other player's counter keeps counting during flight.
//  Width rules
//   - Counters are 8 bit; no wrap below 0.
//   - launch_y = (y >= RAISE) ? y - RAISE : 0.
// TESTING
//  T1 reset: rst_n=0 mid-FLIGHT -> all outputs 0 asynchronously, IDLE after release, no abort.
//  T2 single shot: req=01, p1=(20,30), mirrored=00
//     -> next cycle launch=1, launch=(20,25), dir=0, owner=0.
//     Then eng_done+eng_hit -> hit_pulse=10, cooling=01 for 40 ticks.
//  T3 tie: req=11, both cool, rr=1
//     -> owner=0 launches. After done, with p0 cooling, owner=1 launches next.
//     Reset rr=1 with p0 cooldown 0 and req=11 -> still owner=0 then 1 (round-robin).
//  T4 timeout: launch, no eng_done for 120 ticks -> abort=1 exactly 1 cycle, cooling[owner]=1.
//     Variant: done on the 120th tick -> no abort.
//  T5 saturation: p2_y=3, RAISE=5, mirrored=10, req=10 -> launch_y=0, launch_dir=1.
//  T6 busy gate: eng_busy=1 in IDLE with req=01 -> no launch until eng_busy=0.

Source files
------------

// File: rtl/projectile_scheduler.sv
// Schedules the shared projectile engine between two players: round-robin grant,
// launch origin latching, flight tracking with timeout, hit reporting and per-player cooldown.
module projectile_scheduler #(
  parameter int unsigned COOLDOWN_TICKS = 40,
  parameter int unsigned TIMEOUT_TICKS  = 120,
  parameter int unsigned RAISE          = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_i,
  input  logic [1:0] req_i,
  input  logic [6:0] p1_x_i,
  input  logic [6:0] p1_y_i,
  input  logic [6:0] p2_x_i,
  input  logic [6:0] p2_y_i,
  input  logic [1:0] mirrored_i,
  input  logic       eng_busy_i,
  input  logic       eng_done_i,
  input  logic       eng_hit_i,
  output logic       launch_o,
  output logic [6:0] launch_x_o,
  output logic [6:0] launch_y_o,
  output logic       launch_dir_o,
  output logic       owner_o,
  output logic       abort_o,
  output logic [1:0] hit_pulse_o,
  output logic [1:0] cooling_o
);

  localparam int unsigned CW = 8;
  localparam int unsigned PW = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    FLIGHT = 2'd2
  } state_e;

  state_e              state_q;
  logic                rr_q;
  logic [CW-1:0]       tcnt_q;
  logic [1:0][CW-1:0]  cool_q;
  logic [1:0][CW-1:0]  cool_d;

  logic [1:0]    elig;
  logic          grant;
  logic [PW-1:0] shoot_x;
  logic [PW-1:0] shoot_y;
  logic [PW-1:0] launch_y_d;
  logic          timeout;
  logic          leave;

  // Grant selection and launch origin for the player that would win this cycle
  always_comb begin
    elig    = req_i & ~cooling_o;
    grant   = (elig == 2'b11) ? ~rr_q : elig[1];
    shoot_x = grant ? p2_x_i : p1_x_i;
    shoot_y = grant ? p2_y_i : p1_y_i;
    launch_y_d = (shoot_y >= PW'(RAISE)) ? shoot_y - PW'(RAISE) : '0;
  end

  assign timeout = tick_i && (tcnt_q == CW'(TIMEOUT_TICKS - 1));
  assign leave   = (state_q == FLIGHT) && (eng_done_i || timeout);

  // Cooldown: a load on leaving FLIGHT beats a concurrent tick decrement
  always_comb begin
    cool_d = cool_q;
    for (int i = 0; i < 2; i++) begin
      if (leave && (owner_o == 1'(i))) begin
        cool_d[i] = CW'(COOLDOWN_TICKS);
      end else if (tick_i && (cool_q[i] != '0)) begin
        cool_d[i] = cool_q[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_q         <= 1'b1;
      tcnt_q       <= '0;
      cool_q       <= '0;
      launch_o     <= 1'b0;
      launch_x_o   <= '0;
      launch_y_o   <= '0;
      launch_dir_o <= 1'b0;
      owner_o      <= 1'b0;
      abort_o      <= 1'b0;
      hit_pulse_o  <= '0;
      cooling_o    <= '0;
    end else begin
      launch_o    <= 1'b0;
      abort_o     <= 1'b0;
      hit_pulse_o <= '0;
      cool_q      <= cool_d;
      cooling_o   <= {cool_d[1] != '0, cool_d[0] != '0};
      case (state_q)
        IDLE: begin
          if (!eng_busy_i && (elig != 2'b00)) begin
            state_q      <= LAUNCH;
            launch_o     <= 1'b1;
            owner_o      <= grant;
            launch_x_o   <= shoot_x;
            launch_y_o   <= launch_y_d;
            launch_dir_o <= mirrored_i[grant];
          end
        end
        LAUNCH: begin
          rr_q    <= owner_o;
          tcnt_q  <= '0;
          state_q <= FLIGHT;
        end
        FLIGHT: begin
          // Completion takes priority over a coincident timeout tick
          if (eng_done_i) begin
            state_q <= IDLE;
            if (eng_hit_i) begin
              hit_pulse_o <= owner_o ? 2'b01 : 2'b10;
            end
          end else if (timeout) begin
            abort_o <= 1'b1;
            state_q <= IDLE;
          end else if (tick_i) begin
            tcnt_q <= tcnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_projectile_scheduler.sv
// Directed bench for projectile_scheduler: grant, origin latching, hits, timeout, cooldown, reset.
module tb_projectile_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [1:0] req;
  logic [6:0] p1_x, p1_y, p2_x, p2_y;
  logic [1:0] mirrored;
  logic       eng_busy, eng_done, eng_hit;
  logic       launch;
  logic [6:0] launch_x, launch_y;
  logic       launch_dir, owner, abort_p;
  logic [1:0] hit_pulse, cooling;

  int n_checks = 0;
  int n_pass   = 0;

  projectile_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_i       (tick),
    .req_i        (req),
    .p1_x_i       (p1_x),
    .p1_y_i       (p1_y),
    .p2_x_i       (p2_x),
    .p2_y_i       (p2_y),
    .mirrored_i   (mirrored),
    .eng_busy_i   (eng_busy),
    .eng_done_i   (eng_done),
    .eng_hit_i    (eng_hit),
    .launch_o     (launch),
    .launch_x_o   (launch_x),
    .launch_y_o   (launch_y),
    .launch_dir_o (launch_dir),
    .owner_o      (owner),
    .abort_o      (abort_p),
    .hit_pulse_o  (hit_pulse),
    .cooling_o    (cooling)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  int abort_seen;

  initial begin
    rst_n = 1'b0; tick = 1'b0; req = 2'b00;
    p1_x = 7'd20; p1_y = 7'd30; p2_x = 7'd70; p2_y = 7'd40;
    mirrored = 2'b00; eng_busy = 1'b0; eng_done = 1'b0; eng_hit = 1'b0;
    #1;
    do_reset();
    check("rst_launch", launch, 1'b0);
    check("rst_cooling", cooling, 2'b00);
    check("rst_abort", abort_p, 1'b0);

    // T2 single shot with hit
    req = 2'b01;
    cyc();
    check("t2_launch", launch, 1'b1);
    check("t2_x", launch_x, 7'd20);
    check("t2_y", launch_y, 7'd25);
    check("t2_dir", launch_dir, 1'b0);
    check("t2_owner", owner, 1'b0);
    req = 2'b00;
    cyc();
    check("t2_launch_pulse", launch, 1'b0);
    eng_busy = 1'b1;
    cyc();
    eng_done = 1'b1; eng_hit = 1'b1;
    cyc();
    eng_done = 1'b0; eng_hit = 1'b0; eng_busy = 1'b0;
    check("t2_hit", hit_pulse, 2'b10);
    check("t2_cool", cooling, 2'b01);
    cyc();
    check("t2_hit_pulse", hit_pulse, 2'b00);
    ticks(39);
    check("t2_cool_39", cooling, 2'b01);
    ticks(1);
    check("t2_cool_40", cooling, 2'b00);

    // T3 tie, then round-robin
    do_reset();
    req = 2'b11;
    cyc();
    check("t3_launch0", launch, 1'b1);
    check("t3_owner0", owner, 1'b0);
    cyc();
    eng_done = 1'b1;
    cyc();
    eng_done = 1'b0;
    check("t3_nohit", hit_pulse, 2'b00);
    check("t3_cool0", cooling, 2'b01);
    cyc();
    check("t3_launch1", launch, 1'b1);
    check("t3_owner1", owner, 1'b1);
    check("t3_x1", launch_x, 7'd70);
    check("t3_y1", launch_y, 7'd35);
    req = 2'b00;
    cyc();
    eng_done = 1'b1; eng_hit = 1'b1;
    cyc();
    eng_done = 1'b0; eng_hit = 1'b0;
    check("t3_hit1", hit_pulse, 2'b01);
    check("t3_cool_both", cooling, 2'b11);
    ticks(40);
    check("t3_cool_clear", cooling, 2'b00);
    req = 2'b11;
    cyc();
    check("t3_rr_launch", launch, 1'b1);
    check("t3_rr_owner", owner, 1'b0);

    // T4 timeout abort after 120 ticks in flight
    req = 2'b00;
    cyc();
    ticks(119);
    check("t4_no_abort_119", abort_p, 1'b0);
    ticks(1);
    check("t4_abort", abort_p, 1'b1);
    check("t4_cool", cooling, 2'b01);
    cyc();
    check("t4_abort_pulse", abort_p, 1'b0);
    ticks(40);
    check("t4_cool_clear", cooling, 2'b00);

    // T4 variant: done on the 120th tick suppresses abort
    req = 2'b01;
    cyc();
    check("t4v_launch", launch, 1'b1);
    req = 2'b00;
    cyc();
    ticks(119);
    eng_done = 1'b1;
    ticks(1);
    eng_done = 1'b0;
    check("t4v_no_abort", abort_p, 1'b0);
    check("t4v_cool", cooling, 2'b01);
    cyc();
    check("t4v_no_abort_late", abort_p, 1'b0);
    ticks(40);

    // T5 launch_y saturation and left-facing direction
    p2_x = 7'd50; p2_y = 7'd3; mirrored = 2'b10; req = 2'b10;
    cyc();
    check("t5_launch", launch, 1'b1);
    check("t5_y", launch_y, 7'd0);
    check("t5_dir", launch_dir, 1'b1);
    check("t5_owner", owner, 1'b1);
    check("t5_x", launch_x, 7'd50);
    req = 2'b00;
    cyc();

    // T1 asynchronous reset mid-flight
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_x_async", launch_x, 7'd0);
    check("t1_owner_async", owner, 1'b0);
    check("t1_dir_async", launch_dir, 1'b0);
    cyc();
    rst_n = 1'b1;
    abort_seen = 0;
    for (int k = 0; k < 130; k++) begin
      tick = 1'b1;
      cyc();
      if (abort_p) abort_seen++;
    end
    tick = 1'b0;
    check("t1_no_abort", abort_seen, 0);

    // T6 engine busy gates launch
    eng_busy = 1'b1; req = 2'b01;
    cyc();
    check("t6_gate_a", launch, 1'b0);
    cyc();
    check("t6_gate_b", launch, 1'b0);
    eng_busy = 1'b0;
    cyc();
    check("t6_release", launch, 1'b1);
    check("t6_owner", owner, 1'b0);
    req = 2'b00;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
